// File: rtl/fp_addsub_sequencer.sv
// Control sequencer for the single-precision FP add/sub/mult datapath.
// Steps align -> ALU -> normalize -> round -> (renormalize) -> done.
module fp_addsub_sequencer #(
    parameter int unsigned MAX_SHIFT = 26,
    parameter int unsigned MAX_NORM  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] exp_diff,
    input  logic       carry,
    input  logic       norm_msb,
    input  logic       result_zero,
    input  logic       round_carry,
    input  logic       exp_overflow,
    output logic       smaller_exp_src,
    output logic [7:0] shift_right_qtt,
    output logic [1:0] operation,
    output logic       normalization_src,
    output logic       shift_src,
    output logic       norm_en,
    output logic       round_en,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ALU,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [7:0] MAX_SHIFT_W = 8'(MAX_SHIFT);
    localparam logic [7:0] MAX_NORM_W  = 8'(MAX_NORM);

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic       renorm_q, renorm_d;
    logic       first_q, first_d;
    logic       ovf_q, ovf_d;
    logic       ill_q, ill_d;

    logic [7:0] abs_diff;
    logic [7:0] sat_diff;

    // Magnitude of the exponent difference, clamped to the shifter range;
    // -128 negates to 8'h80, which is above the clamp and saturates too.
    always_comb begin
        abs_diff = exp_diff[7] ? (~exp_diff + 8'd1) : exp_diff;
        sat_diff = (abs_diff > MAX_SHIFT_W) ? MAX_SHIFT_W : abs_diff;
    end

    // State and sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            cnt_q    <= 8'd0;
            renorm_q <= 1'b0;
            first_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            renorm_q <= renorm_d;
            first_q  <= first_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    // Next-state logic and datapath select decode.
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        cnt_d             = cnt_q;
        renorm_d          = renorm_q;
        first_d           = first_q;
        ovf_d             = ovf_q;
        ill_d             = ill_q;
        smaller_exp_src   = 1'b0;
        shift_right_qtt   = 8'd0;
        operation         = 2'b00;
        normalization_src = 1'b0;
        shift_src         = 1'b0;
        norm_en           = 1'b0;
        round_en          = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        overflow          = 1'b0;
        illegal           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    cnt_d    = 8'd0;
                    renorm_d = 1'b0;
                    first_d  = 1'b0;
                    ovf_d    = 1'b0;
                    ill_d    = (op == OP_ILL);
                    if (op == OP_ILL) begin
                        state_d = S_DONE;
                    end else if (op == OP_MUL) begin
                        state_d = S_ALU;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end

            S_ALIGN: begin
                busy            = 1'b1;
                smaller_exp_src = ~exp_diff[7];
                shift_right_qtt = sat_diff;
                state_d         = S_ALU;
            end

            S_ALU: begin
                busy      = 1'b1;
                operation = op_q;
                first_d   = 1'b1;
                state_d   = S_NORM;
            end

            S_NORM: begin
                busy              = 1'b1;
                normalization_src = renorm_q;
                first_d           = 1'b0;
                if (exp_overflow) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else if (carry && first_q) begin
                    norm_en   = 1'b1;
                    shift_src = 1'b1;
                end else if (result_zero) begin
                    state_d = S_ROUND;
                end else if (!norm_msb) begin
                    norm_en = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    // Too many left shifts: mantissa is effectively zero.
                    if (cnt_q + 8'd1 >= MAX_NORM_W) begin
                        state_d = S_ROUND;
                    end
                end else begin
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                busy     = 1'b1;
                round_en = 1'b1;
                if (round_carry && !renorm_q) begin
                    normalization_src = 1'b1;
                    renorm_d          = 1'b1;
                    cnt_d             = 8'd0;
                    state_d           = S_NORM;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done     = 1'b1;
                overflow = ovf_q;
                illegal  = ill_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed bench for fp_addsub_sequencer: a vector table replayed
// through a reactive datapath stub, plus reset and held-start cases.
module tb_fp_addsub_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] exp_diff;
    logic       carry;
    logic       norm_msb;
    logic       result_zero;
    logic       round_carry;
    logic       exp_overflow;
    logic       smaller_exp_src;
    logic [7:0] shift_right_qtt;
    logic [1:0] operation;
    logic       normalization_src;
    logic       shift_src;
    logic       norm_en;
    logic       round_en;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       illegal;

    int checks;
    int errors;

    fp_addsub_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .op                (op),
        .exp_diff          (exp_diff),
        .carry             (carry),
        .norm_msb          (norm_msb),
        .result_zero       (result_zero),
        .round_carry       (round_carry),
        .exp_overflow      (exp_overflow),
        .smaller_exp_src   (smaller_exp_src),
        .shift_right_qtt   (shift_right_qtt),
        .operation         (operation),
        .normalization_src (normalization_src),
        .shift_src         (shift_src),
        .norm_en           (norm_en),
        .round_en          (round_en),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow),
        .illegal           (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus: op, exp_diff, carry, zero, round_carry, overflow, and the
    // number of left shifts before the mantissa MSB appears (nlow).
    // Expected: done cycle, smaller src, shift qtt, left/right shifts,
    // round cycles, overflow, illegal, renormalize-pass seen.
    typedef struct {
        logic [1:0] op;
        logic [7:0] ed;
        bit         cy;
        bit         z;
        bit         rc;
        bit         ov;
        int         nlow;
        int         dc;
        int         sm;
        int         qtt;
        int         l;
        int         r;
        int         rnd;
        int         eov;
        int         eil;
        int         ens;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [17:0] out_pack();
        return {smaller_exp_src, shift_right_qtt, operation,
                normalization_src, shift_src, norm_en, round_en,
                busy, done, overflow, illegal};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v, input bit hold);
        int  lefts, rights, rounds, busys, dcyc;
        int  sm, qtt, aop;
        int  ovf, ill, nsrc;
        bit  seen;
        string t;
        lefts  = 0;
        rights = 0;
        rounds = 0;
        busys  = 0;
        dcyc   = 0;
        sm     = -1;
        qtt    = -1;
        aop    = -1;
        ovf    = 0;
        ill    = 0;
        nsrc   = 0;
        seen   = 1'b0;
        t = $sformatf("v%0d", idx);

        @(negedge clk);
        start        = 1'b1;
        op           = v.op;
        exp_diff     = v.ed;
        carry        = v.cy;
        result_zero  = v.z;
        round_carry  = v.rc;
        exp_overflow = v.ov;
        norm_msb     = (v.nlow == 0);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;

        for (int c = 1; c <= 60 && !seen; c++) begin
            norm_msb = (lefts >= v.nlow);
            #1;
            if (c == 1) begin
                sm  = int'(smaller_exp_src);
                qtt = int'(shift_right_qtt);
            end
            if (c == ((v.op == 2'b10) ? 1 : 2))
                aop = int'(operation);
            if (norm_en && !shift_src) lefts++;
            if (norm_en && shift_src) rights++;
            if (round_en) rounds++;
            if (busy) busys++;
            if (busy && normalization_src && !round_en) nsrc = 1;
            if (done) begin
                seen = 1'b1;
                dcyc = c;
                ovf  = int'(overflow);
                ill  = int'(illegal);
            end else begin
                @(posedge clk);
                #1;
            end
        end

        if (!seen) begin
            chk({t, "_done_timeout"}, 0, 1);
        end else begin
            if (v.eil != 0)
                chk({t, "_done_cyc_le2"}, int'(dcyc <= 2), 1);
            else
                chk({t, "_done_cyc"}, dcyc, v.dc);
        end
        chk({t, "_smaller_src"}, sm, v.sm);
        chk({t, "_shift_qtt"}, qtt, v.qtt);
        if (v.eil == 0) chk({t, "_operation"}, aop, int'(v.op));
        chk({t, "_left_shifts"}, lefts, v.l);
        chk({t, "_right_shifts"}, rights, v.r);
        chk({t, "_round_cycles"}, rounds, v.rnd);
        chk({t, "_overflow"}, ovf, v.eov);
        chk({t, "_illegal"}, ill, v.eil);
        chk({t, "_renorm_src"}, nsrc, v.ens);
        chk({t, "_busy_cycles"}, busys, (v.eil != 0) ? 0 : v.dc - 1);

        // Cycle after done: idle, no repeat pulse even if start is held.
        @(posedge clk);
        #1;
        chk({t, "_post_done"}, int'(done), 0);
        chk({t, "_post_busy"}, int'(busy), 0);
        start = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        op           = 2'b00;
        exp_diff     = 8'd0;
        carry        = 1'b0;
        norm_msb     = 1'b0;
        result_zero  = 1'b0;
        round_carry  = 1'b0;
        exp_overflow = 1'b0;

        //         op     ed     cy z  rc ov nlow dc sm qtt l  r  rnd ov il ns
        vecs[0]  = '{2'b00, 8'd3,   0, 0, 0, 0, 0,  5, 1, 3,  0, 0, 1, 0, 0, 0};
        vecs[1]  = '{2'b01, 8'hF6,  0, 0, 0, 0, 2,  7, 0, 10, 2, 0, 1, 0, 0, 0};
        vecs[2]  = '{2'b00, 8'd100, 1, 0, 1, 0, 0,  8, 1, 26, 0, 1, 2, 0, 0, 1};
        vecs[3]  = '{2'b11, 8'd7,   0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 0};
        vecs[4]  = '{2'b00, 8'd5,   0, 0, 0, 1, 0,  4, 1, 5,  0, 0, 0, 1, 0, 0};
        vecs[5]  = '{2'b10, 8'd50,  0, 0, 0, 0, 0,  4, 0, 0,  0, 0, 1, 0, 0, 0};
        vecs[6]  = '{2'b01, 8'h80,  0, 0, 0, 0, 0,  5, 0, 26, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{2'b00, 8'd0,   0, 1, 0, 0, 99, 5, 1, 0,  0, 0, 1, 0, 0, 0};
        vecs[8]  = '{2'b00, 8'hE7,  0, 0, 0, 0, 99, 28, 0, 25, 24, 0, 1, 0, 0, 0};
        vecs[9]  = '{2'b00, 8'h7F,  1, 1, 0, 0, 99, 6, 1, 26, 0, 1, 1, 0, 0, 0};
        vecs[10] = '{2'b01, 8'd26,  1, 0, 0, 1, 0,  4, 1, 26, 0, 0, 0, 1, 0, 0};

        #12;
        chk("reset_outputs", int'(out_pack()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", int'(out_pack()), 0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i], 1'b0);

        // Start held high through the whole op and its DONE cycle.
        run_vec(100, vecs[1], 1'b1);

        // Asynchronous reset while shifting in NORM: no done afterwards.
        @(negedge clk);
        start        = 1'b1;
        op           = 2'b00;
        exp_diff     = 8'd4;
        carry        = 1'b0;
        result_zero  = 1'b0;
        round_carry  = 1'b0;
        exp_overflow = 1'b0;
        norm_msb     = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_norm_en", int'(norm_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(out_pack()), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("reset_no_done", int'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(200, vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
